stack_controller: RTL
=====================

# stack_controller

Push/pop sequencer for the single-port `stack_ram` block RAM (17-bit words, 14-bit address, registered write-first output). It sits directly upstream of the RAM. It keeps the stack pointer, full/empty/overflow/underflow status and a req/ack handshake for the vision datapath (blob/flood-fill engines). It drives the RAM address, data and write-enable, and captures the RAM's registered read data.

## Interface
Parameters:
- `RAM_ADDR_BITS`, 14: RAM address width; depth is 2**RAM_ADDR_BITS.
- `RAM_WIDTH`, 17: word width.

Ports:
- `clka` in 1: the block's single clock; shared with `stack_ram`.
- `reset` in 1: asynchronous, active-high reset.
- `clear` in 1: synchronous stack flush.
- `push_req` in 1: push request; held by the requester until `push_ack`.
- `push_data` in RAM_WIDTH: word to push; stable while `push_req` is high.
- `push_ack` out 1: one-cycle pulse; push done or dropped.
- `pop_req` in 1: pop request; held by the requester until `pop_ack`.
- `pop_data` out RAM_WIDTH: popped word; valid when `pop_ack` is high, and held afterwards.
- `pop_ack` out 1: one-cycle pulse.
- `depth` out RAM_ADDR_BITS+1: number of stored entries, 0..2**RAM_ADDR_BITS.
- `full`, `empty` out 1: `depth`==2**RAM_ADDR_BITS and `depth`==0.
- `overflow`, `underflow` out 1: sticky error flags.
- `ram_addr` out RAM_ADDR_BITS: to `stack_ram` `addra`.
- `ram_din` out RAM_WIDTH: to `dina`.
- `ram_we` out 1: to `wea`.
- `ram_dout` in RAM_WIDTH: from `douta`.

## Operation
- Reset values:
  - `depth`=0, `empty`=1, `full`=0.
  - `push_ack`, `pop_ack`, `overflow`, `underflow` = 0.
  - `pop_data`=0, `ram_addr`=0, `ram_din`=0, `ram_we`=0.
  - FSM in IDLE.
- All outputs are registered.
- FSM states: IDLE, PUSH_ACK, POP_RD, POP_CAP, POP_ACK.
- IDLE:
  - Samples requests; `push_req` has priority over `pop_req`. The losing request stays pending and is served on the next return to IDLE.
- Push, not full:
  - Registers `ram_addr`<=`depth`, `ram_din`<=`push_data`, `ram_we`<=1, `push_ack`<=1, `depth`<=`depth`+1.
  - Goes to PUSH_ACK.
- Push when full:
  - No write; `depth` unchanged; `overflow`<=1; `push_ack`<=1; goes to PUSH_ACK.
- PUSH_ACK:
  - `ram_we`<=0, `push_ack`<=0.
  - Requests are ignored; the requester deasserts here. Returns to IDLE.
- Pop, not empty:
  - `ram_addr`<=`depth`-1, `ram_we`<=0, `depth`<=`depth`-1; goes to POP_RD.
- POP_RD: the RAM latches the address. Goes to POP_CAP.
- POP_CAP: `pop_data`<=`ram_dout`, `pop_ack`<=1; goes to POP_ACK.
- Pop when empty:
  - `underflow`<=1, `pop_data`<=0, `pop_ack`<=1; goes to POP_ACK.
- POP_ACK: `pop_ack`<=0; returns to IDLE.
- Arithmetic:
  - `depth` is unsigned, RAM_ADDR_BITS+1 wide; it never wraps.
  - `ram_addr` is the low RAM_ADDR_BITS bits of the computed address.
- `clear`:
  - Sets `depth`<=0, `overflow`<=0, `underflow`<=0, `ram_we`<=0.
  - Forces IDLE from any state. An in-flight operation is aborted with no ack; requesters must re-request.
  - Overrides a request sampled in the same cycle.
- Reset asserted mid-operation: immediate return to reset values; no ack is issued.

## Timing
- Push: request sampled at edge N; `push_ack` and `ram_we` high in cycle N+1; the RAM write occurs at edge N+2. Peak rate is 1 push per 2 cycles.
- Pop: request sampled at edge N; `pop_ack` high in cycle N+3 with `pop_data` valid. Peak rate is 1 pop per 4 cycles.
- A push at `depth`=k followed by a pop returns the same word. The RAM write at edge N+2 precedes the pop read at edge ≥N+3.
- `full`, `empty` and `depth` update on the same edge as the accepted request.

## Configuration
- `STACK_WATERMARK_EN` defined:
  - Adds output `high_water` (RAM_ADDR_BITS+1 wide, reset 0).
  - Updates to max(`high_water`, new `depth`) on every accepted push.
  - Cleared by `reset` only, not by `clear`.
- Undefined: the port and its logic are absent.

## Test plan
- Reset, then push 0x1ABCD, 0x00001, 0x15555: `push_ack` arrives 1 cycle after each sample, `depth`=3. Three pops return 0x15555, 0x00001, 0x1ABCD, each `pop_ack` 3 cycles after sample; `empty`=1 at the end.
- Pop on an empty stack: `pop_ack` after 1 cycle, `pop_data`=0, `underflow`=1 and sticky; `depth` stays 0.
- Fill to 16384 entries (`full`=1), then push 0x12345: `overflow`=1, `depth`=16384, no `ram_we`. Next pop returns the last stored word.
- `push_req` and `pop_req` asserted together at `depth`=1 with data 0x00042: push is served first (`depth`=2), then the pop returns 0x00042.
- `clear` in POP_RD: no `pop_ack`; `depth`=0; flags cleared; FSM in IDLE next cycle.
- With `STACK_WATERMARK_EN`: push 5, pop 3, push 1 → `high_water`=5; `clear` leaves it at 5.

Source files
------------

// File: rtl/stack_controller.sv
// Push/pop sequencer in front of a single-port, write-first block RAM stack.
// Optional high-water tracking is enabled by defining STACK_WATERMARK_EN.
module stack_controller #(
  parameter int RAM_ADDR_BITS = 14,
  parameter int RAM_WIDTH     = 17
) (
  input  logic                     clka,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push_req,
  input  logic [RAM_WIDTH-1:0]     push_data,
  output logic                     push_ack,
  input  logic                     pop_req,
  output logic [RAM_WIDTH-1:0]     pop_data,
  output logic                     pop_ack,
  output logic [RAM_ADDR_BITS:0]   depth,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow,
  output logic                     underflow,
  output logic [RAM_ADDR_BITS-1:0] ram_addr,
  output logic [RAM_WIDTH-1:0]     ram_din,
  output logic                     ram_we,
  input  logic [RAM_WIDTH-1:0]     ram_dout
`ifdef STACK_WATERMARK_EN
  ,
  output logic [RAM_ADDR_BITS:0]   high_water
`endif
);

  localparam logic [RAM_ADDR_BITS:0] DEPTH_MAX = {1'b1, {RAM_ADDR_BITS{1'b0}}};

  typedef enum logic [2:0] {
    IDLE,
    PUSH_ACK,
    POP_RD,
    POP_CAP,
    POP_ACK
  } state_t;

  state_t                   state_q, state_d;
  logic [RAM_ADDR_BITS:0]   depth_q, depth_d;
  logic                     full_q, full_d;
  logic                     empty_q, empty_d;
  logic                     overflow_q, overflow_d;
  logic                     underflow_q, underflow_d;
  logic                     push_ack_q, push_ack_d;
  logic                     pop_ack_q, pop_ack_d;
  logic [RAM_WIDTH-1:0]     pop_data_q, pop_data_d;
  logic [RAM_ADDR_BITS-1:0] ram_addr_q, ram_addr_d;
  logic [RAM_WIDTH-1:0]     ram_din_q, ram_din_d;
  logic                     ram_we_q, ram_we_d;
  logic                     push_accept;

  always_comb begin
    state_d     = state_q;
    depth_d     = depth_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    push_ack_d  = push_ack_q;
    pop_ack_d   = pop_ack_q;
    pop_data_d  = pop_data_q;
    ram_addr_d  = ram_addr_q;
    ram_din_d   = ram_din_q;
    ram_we_d    = ram_we_q;
    push_accept = 1'b0;

    case (state_q)
      IDLE: begin
        if (push_req) begin
          if (!full_q) begin
            ram_addr_d  = depth_q[RAM_ADDR_BITS-1:0];
            ram_din_d   = push_data;
            ram_we_d    = 1'b1;
            depth_d     = depth_q + 1'b1;
            push_accept = 1'b1;
          end else begin
            overflow_d = 1'b1;
          end
          push_ack_d = 1'b1;
          state_d    = PUSH_ACK;
        end else if (pop_req) begin
          if (!empty_q) begin
            ram_addr_d = RAM_ADDR_BITS'(depth_q - 1'b1);
            ram_we_d   = 1'b0;
            depth_d    = depth_q - 1'b1;
            state_d    = POP_RD;
          end else begin
            underflow_d = 1'b1;
            pop_data_d  = '0;
            pop_ack_d   = 1'b1;
            state_d     = POP_ACK;
          end
        end
      end
      PUSH_ACK: begin
        ram_we_d   = 1'b0;
        push_ack_d = 1'b0;
        state_d    = IDLE;
      end
      POP_RD: begin
        // RAM registers the address on this edge; data appears next cycle.
        state_d = POP_CAP;
      end
      POP_CAP: begin
        pop_data_d = ram_dout;
        pop_ack_d  = 1'b1;
        state_d    = POP_ACK;
      end
      POP_ACK: begin
        pop_ack_d = 1'b0;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Flush wins over anything sampled this cycle; aborted operations get no ack.
    if (clear) begin
      depth_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
      ram_we_d    = 1'b0;
      push_ack_d  = 1'b0;
      pop_ack_d   = 1'b0;
      push_accept = 1'b0;
      state_d     = IDLE;
    end

    full_d  = (depth_d == DEPTH_MAX);
    empty_d = (depth_d == '0);
  end

  always_ff @(posedge clka or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      depth_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      push_ack_q  <= 1'b0;
      pop_ack_q   <= 1'b0;
      pop_data_q  <= '0;
      ram_addr_q  <= '0;
      ram_din_q   <= '0;
      ram_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      depth_q     <= depth_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      push_ack_q  <= push_ack_d;
      pop_ack_q   <= pop_ack_d;
      pop_data_q  <= pop_data_d;
      ram_addr_q  <= ram_addr_d;
      ram_din_q   <= ram_din_d;
      ram_we_q    <= ram_we_d;
    end
  end

`ifdef STACK_WATERMARK_EN
  logic [RAM_ADDR_BITS:0] high_water_q, high_water_d;

  // Survives clear on purpose: it records the peak since the last reset.
  always_comb begin
    high_water_d = high_water_q;
    if (push_accept && (depth_d > high_water_q)) begin
      high_water_d = depth_d;
    end
  end

  always_ff @(posedge clka or posedge reset) begin
    if (reset) begin
      high_water_q <= '0;
    end else begin
      high_water_q <= high_water_d;
    end
  end

  assign high_water = high_water_q;
`else
  // Without the watermark option the accepted-push strobe has no consumer.
  logic unused_push_accept;
  assign unused_push_accept = push_accept;
`endif

  assign depth     = depth_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign push_ack  = push_ack_q;
  assign pop_ack   = pop_ack_q;
  assign pop_data  = pop_data_q;
  assign ram_addr  = ram_addr_q;
  assign ram_din   = ram_din_q;
  assign ram_we    = ram_we_q;

endmodule
